// File: rtl/led_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Package  : led_pkg
//  Purpose  : Shared types and default sizing for the LED PWM driver and its
//             breathing-duty generator.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package led_pkg;

   // Default PWM counter / duty width in bits (period = 2**PWM_W cycles).
   localparam int PWM_W_DEF    = 8;

   // Default number of PWM periods per breathing duty step.
   localparam int STEP_DIV_DEF = 196;

   // Widest supported STEP_DIV is 65535, so a 16-bit step counter suffices.
   localparam int STEP_CNT_W   = 16;

   // Breathing ramp direction.
   typedef enum logic [0:0] {
      RISE = 1'b0,
      FALL = 1'b1
   } breath_state_t;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_breath_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : led_breath_gen
//  Purpose  : Triangle-wave duty generator. Counts PWM period boundaries and,
//             every STEP_DIV boundaries, moves duty_br one step up (RISE) or
//             down (FALL), turning around exactly at 2**PWM_W-1 and at 0.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module led_breath_gen
   import led_pkg::*;
#(
   parameter int PWM_W    = PWM_W_DEF,
   parameter int STEP_DIV = STEP_DIV_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bnd_stb,
   output logic [PWM_W-1:0] duty_br
);

   localparam logic [PWM_W-1:0]      DUTY_TOP  = '1;
   localparam logic [PWM_W-1:0]      DUTY_ZERO = '0;
   localparam logic [PWM_W-1:0]      DUTY_ONE  = PWM_W'(1);
   localparam logic [STEP_CNT_W-1:0] STEP_LAST = STEP_CNT_W'(STEP_DIV - 1);
   localparam logic [STEP_CNT_W-1:0] STEP_ONE  = STEP_CNT_W'(1);

   breath_state_t           state;
   breath_state_t           state_nxt;
   logic [PWM_W-1:0]        duty_nxt;
   logic [STEP_CNT_W-1:0]   step_cnt;
   logic [STEP_CNT_W-1:0]   step_nxt;

   // State, duty and step-count registers; reset restarts the ramp at 0 rising.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= RISE;
         duty_br  <= DUTY_ZERO;
         step_cnt <= '0;
      end else begin
         state    <= state_nxt;
         duty_br  <= duty_nxt;
         step_cnt <= step_nxt;
      end
   end

   // Next-state logic: only period boundaries advance anything, and only the
   // last boundary of each step interval moves the duty.
   always_comb begin
      state_nxt = state;
      duty_nxt  = duty_br;
      step_nxt  = step_cnt;

      if (bnd_stb) begin
         if (step_cnt == STEP_LAST) begin
            step_nxt = '0;
            case (state)
               RISE: begin
                  // Stop at the top rather than wrapping to zero.
                  if (duty_br != DUTY_TOP) begin
                     duty_nxt = duty_br + DUTY_ONE;
                  end
                  if (duty_nxt == DUTY_TOP) begin
                     state_nxt = FALL;
                  end
               end
               FALL: begin
                  // Stop at zero rather than wrapping to the top.
                  if (duty_br != DUTY_ZERO) begin
                     duty_nxt = duty_br - DUTY_ONE;
                  end
                  if (duty_nxt == DUTY_ZERO) begin
                     state_nxt = RISE;
                  end
               end
               default: begin
                  state_nxt = RISE;
               end
            endcase
         end else begin
            step_nxt = step_cnt + STEP_ONE;
         end
      end
   end

endmodule : led_breath_gen
`default_nettype wire

// File: rtl/led_pwm_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : led_pwm_driver
//  Purpose  : Four-channel LED PWM stage. A free-running counter defines a
//             2**PWM_W-cycle period; the LED pattern and duty are latched once
//             per period so brightness never changes mid-period.
//  Options  : LED_PWM_BREATH_EN - when defined, duty comes from the breathing
//             generator (led_breath_gen) and duty_set is ignored; otherwise
//             duty_set is sampled at each period boundary.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module led_pwm_driver
   import led_pkg::*;
#(
   parameter int PWM_W    = PWM_W_DEF,
   parameter int STEP_DIV = STEP_DIV_DEF
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [3:0]       led_in,
   input  logic [PWM_W-1:0] duty_set,
   output logic [3:0]       led_out,
   output logic             pwm_sof
);

   localparam logic [PWM_W-1:0] CNT_MAX = '1;
   localparam logic [PWM_W-1:0] CNT_ONE = PWM_W'(1);

   logic [PWM_W-1:0] pwm_cnt;
   logic [PWM_W-1:0] duty_q;
   logic [PWM_W-1:0] duty_eff;
   logic [3:0]       led_q;
   logic             period_end;
   logic             sof_pend;

   // Last cycle of the period: capture point for pattern and duty.
   assign period_end = (pwm_cnt == CNT_MAX);

`ifdef LED_PWM_BREATH_EN
   logic [PWM_W-1:0] duty_br;
   logic             unused_duty_set;

   assign unused_duty_set = ^duty_set;

   led_breath_gen #(
      .PWM_W    (PWM_W),
      .STEP_DIV (STEP_DIV)
   ) u_breath (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .bnd_stb (period_end),
      .duty_br (duty_br)
   );

   assign duty_eff = duty_br;
`else
   logic [STEP_CNT_W-1:0] unused_step_div;

   assign unused_step_div = STEP_CNT_W'(STEP_DIV);
   assign duty_eff        = duty_set;
`endif

   // Free-running period counter; wraps naturally at 2**PWM_W.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + CNT_ONE;
      end
   end

   // Latch pattern and duty once per period so a period is never split.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         led_q  <= '0;
         duty_q <= '0;
      end else if (period_end) begin
         led_q  <= led_in;
         duty_q <= duty_eff;
      end
   end

   // Registered PWM compare; a duty of all-ones leaves one dark cycle.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         led_out <= '0;
      end else begin
         led_out <= led_q & {4{pwm_cnt < duty_q}};
      end
   end

   // Two-stage start-of-period flag so it lines up with the first led_out
   // cycle that uses the freshly latched pattern and duty.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         sof_pend <= 1'b0;
         pwm_sof  <= 1'b0;
      end else begin
         sof_pend <= period_end;
         pwm_sof  <= sof_pend;
      end
   end

endmodule : led_pwm_driver
`default_nettype wire

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 Parameter PWM_W, default 8, PWM counter and duty width in bits.
REQ-002 Parameter STEP_DIV, default 196, number of PWM periods per breathing duty step (range 1..65535).
REQ-003 sys_clk  input  1  single system clock; all logic SHALL be rising-edge.
REQ-004 sys_rst_n  input  1  reset, synchronous and active-low.
REQ-005 led_in  input  4  LED on/off pattern from the upstream running-light stage; one bit per LED, 1 = lit.
REQ-006 duty_set  input  PWM_W  static brightness, used only when breathing is compiled out.
REQ-007 led_out  output  4  PWM-modulated LED drive, registered.
REQ-008 pwm_sof  output  1  one-cycle pulse on the first cycle of each PWM period, registered.

Function
REQ-009 pwm_cnt SHALL free-run 0..2^PWM_W-1, incrementing every cycle and wrapping to 0.
REQ-010 Period boundary = cycle where pwm_cnt == 2^PWM_W-1; the period is 2^PWM_W cycles (256 at default).
REQ-011 At each period boundary, led_in SHALL be captured into led_q, and the effective duty SHALL be captured into duty_q; neither changes mid-period.
REQ-012 Each led_out[i] SHALL be led_q[i] AND (pwm_cnt < duty_q), registered, so it lags pwm_cnt by one cycle.
REQ-013 duty_q == 0 SHALL give led_out constantly 0; duty_q == 255 SHALL give 255 on-cycles per 256-cycle period (max).
REQ-014 pwm_sof SHALL be 1 in the cycle after each period boundary, i.e. aligned with the first led_out cycle of a new period.
REQ-015 A change on led_in SHALL appear on led_out no earlier than the first cycle of the next period and no later than 2^PWM_W+1 cycles after the change.
REQ-016 Breathing FSM states: RISE, FALL; step_cnt counts period boundaries 0..STEP_DIV-1.
REQ-017 When step_cnt reaches STEP_DIV-1 at a boundary: step_cnt SHALL wrap to 0 and duty_br SHALL step by 1 (RISE: +1; FALL: -1).
REQ-018 RISE -> FALL when duty_br steps to 2^PWM_W-1; FALL -> RISE when duty_br steps to 0; duty_br SHALL never wrap or saturate past its end values.
REQ-019 led_in bits that are 0 SHALL keep the LED off regardless of duty or FSM state.

Reset
REQ-020 While sys_rst_n == 0 at a rising edge: pwm_cnt=0, led_q=0, duty_q=0, duty_br=0, step_cnt=0, state=RISE, led_out=4'b0000, pwm_sof=0.
REQ-021 Reset asserted mid-period or mid-ramp SHALL abandon the period; the first pwm_sof after release SHALL occur 2^PWM_W cycles after the first non-reset edge.

Configuration
REQ-022 Macro LED_PWM_BREATH_EN defined: effective duty = duty_br from the breathing FSM; duty_set ignored.
REQ-023 LED_PWM_BREATH_EN undefined: FSM, duty_br, step_cnt SHALL not be built; effective duty = duty_set sampled at the period boundary.

Structure
REQ-024 Shared package led_pkg SHALL hold the breathing state enum (RISE, FALL), PWM_W default and STEP_DIV default.
REQ-025 Breathing FSM SHALL be sub-module led_breath_gen (inputs: clock, reset, period-boundary strobe; output: duty_br), instantiated only under LED_PWM_BREATH_EN.

Verification
REQ-026 Breath off, duty_set=64, led_in=4'b0001 -> led_out[0] high exactly 64 of every 256 cycles, led_out[3:1]=0, pwm_sof every 256 cycles.
REQ-027 Breath off, duty_set=0 then 255 -> led_out all 0 for full periods; then 255 on-cycles per period for lit bits.
REQ-028 Breath off, led_in changes 4'b0001->4'b0010 at pwm_cnt=100 -> led_out[0] keeps current period, led_out[1] first high on cycle after next boundary.
REQ-029 Breath on, STEP_DIV=1, led_in=4'b1111 -> duty_q rises 0..255 over 255 periods, falls to 0, then rises again; never wraps.
REQ-030 Reset asserted for 3 cycles at pwm_cnt=200 with duty 128 -> led_out=0, pwm_sof=0 during reset; first pwm_sof 256 cycles after release; ramp restarts from 0 in RISE.
